// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory-access stage with req/ack data bus and MEM/WB register
//
// Purpose: issues loads/stores for the EX/MEM slot over a req/ack bus, formats
// load data, stalls upstream while an access is outstanding, aborts on ack
// timeout and owns the MEM/WB pipeline register.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   valid_MEM .. reg_write_MEM       EX/MEM bundle (held stable while stall_MEM)
//   dmem_req/we/addr/be/wdata        data-memory request (out)
//   dmem_ack/rdata                   data-memory response (in)
//   stall_MEM                        upstream hold
//   misalign_MEM, bus_err_MEM        one-cycle drop / abort pulses
//   valid_WB .. pcPlus4_WB           registered MEM/WB bundle
module mem_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_MEM,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] store_data_MEM,
  input  logic [31:0] pcPlus4_MEM,
  input  logic [1:0]  result_set_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        reg_write_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_MEM,
  output logic        misalign_MEM,
  output logic        bus_err_MEM,
  output logic        valid_WB,
  output logic        reg_write_WB,
  output logic [4:0]  rd_WB,
  output logic [1:0]  result_set_WB,
  output logic [31:0] alu_result_WB,
  output logic [31:0] mem_data_WB,
  output logic [31:0] pcPlus4_WB
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             w_memop, w_legal, w_aligned, w_access, w_bad, w_in_wait;
  logic             w_timeout;
  logic [CNT_W-1:0] w_req_cycles;
  logic [31:0]      w_lane, w_load;

  assign w_memop   = valid_MEM & (mem_read_MEM | mem_write_MEM);
  assign w_in_wait = (r_state == S_WAIT);

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (mem_read_MEM)
      w_legal = (funct3_MEM[1:0] != 2'b11) && !(funct3_MEM[2] && funct3_MEM[1]);
    else
      w_legal = !funct3_MEM[2] && (funct3_MEM[1:0] != 2'b11);
    case (funct3_MEM[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = !alu_result_MEM[0];
      2'b10:   w_aligned = (alu_result_MEM[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_access = w_memop & w_legal & w_aligned;
  assign w_bad    = w_memop & ~(w_legal & w_aligned);

  // Request is gated by rst_n so it drops the instant reset asserts, even mid-WAIT.
  assign dmem_req = rst_n & (w_in_wait | w_access);

  // Count of request cycles including the current one.
  assign w_req_cycles = w_in_wait ? (r_cnt + 1'b1) : CNT_W'(1);
  assign w_timeout    = (ACK_TIMEOUT != 0) && dmem_req && !dmem_ack &&
                        (w_req_cycles == CNT_W'(ACK_TIMEOUT));

  assign stall_MEM    = dmem_req & ~dmem_ack & ~w_timeout;
  assign misalign_MEM = rst_n & w_bad & ~w_in_wait;
  assign bus_err_MEM  = w_timeout;

  assign dmem_we   = mem_write_MEM;
  assign dmem_addr = {alu_result_MEM[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_MEM;
    case (funct3_MEM[1:0])
      2'b00:   dmem_wdata = {4{store_data_MEM[7:0]}};
      2'b01:   dmem_wdata = {2{store_data_MEM[15:0]}};
      default: dmem_wdata = store_data_MEM;
    endcase
    if (mem_write_MEM) begin
      case (funct3_MEM[1:0])
        2'b00:   dmem_be = 4'b0001 << alu_result_MEM[1:0];
        2'b01:   dmem_be = alu_result_MEM[1] ? 4'b1100 : 4'b0011;
        default: dmem_be = 4'b1111;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0, then size/extend it.
  assign w_lane = dmem_rdata >> {alu_result_MEM[1:0], 3'b000};

  always_comb begin
    w_load = w_lane;
    case (funct3_MEM)
      3'b000:  w_load = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && !dmem_ack && !w_timeout) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (dmem_ack || w_timeout) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      rd_WB         <= '0;
      result_set_WB <= '0;
      alu_result_WB <= '0;
      mem_data_WB   <= '0;
      pcPlus4_WB    <= '0;
    end else if (stall_MEM || w_bad || w_timeout) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      rd_WB         <= '0;
      result_set_WB <= '0;
      alu_result_WB <= '0;
      mem_data_WB   <= '0;
      pcPlus4_WB    <= '0;
    end else begin
      valid_WB      <= valid_MEM;
      reg_write_WB  <= reg_write_MEM;
      rd_WB         <= rd_MEM;
      result_set_WB <= result_set_MEM;
      alu_result_WB <= alu_result_MEM;
      mem_data_WB   <= (w_access && mem_read_MEM) ? w_load : 32'd0;
      pcPlus4_WB    <= pcPlus4_MEM;
    end
  end

endmodule
